// File: rtl/module_keypad_decoder.sv
// 4x4 matrix keypad scanner/decoder. Synchronises the active-low columns, drives the
// active-low rows, debounces one key press and release, and emits a 4-bit key code with a
// single-cycle valid strobe. Requests a scan freeze (o_stop) while a key is being handled.
module module_keypad_decoder #(
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [1:0] i_cont_out,
  input  logic [3:0] i_col_n,
  output logic [3:0] o_row_n,
  output logic       o_stop,
  output logic [3:0] o_key_code,
  output logic       o_key_valid
);

  localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES + 3);

  // Last count value before the transition fires, so the compare uses the current count.
  localparam logic [CntW-1:0] PressLast = CntW'(DEBOUNCE_CYCLES + 1);
  localparam logic [CntW-1:0] RelLast   = CntW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CntW-1:0] Settle    = CntW'(2);

  typedef enum logic [2:0] {
    StScan,
    StDebPress,
    StEmit,
    StHold,
    StDebRel
  } state_e;

  state_e          r_state;
  state_e          w_state_next;
  logic [CntW-1:0] r_cnt;
  logic [CntW-1:0] w_cnt_next;
  logic [1:0]      r_row_lat;
  logic [1:0]      w_row_lat_next;
  logic [3:0]      r_col_lat;
  logic [3:0]      w_col_lat_next;
  logic [3:0]      r_col_s1;
  logic [3:0]      r_col_s2;
  logic [1:0]      r_row_d1;
  logic [1:0]      r_row_d2;
  logic [3:0]      r_key_code;
  logic            r_key_valid;
  logic            w_stop;
  logic            w_one_low;
  logic [1:0]      w_row_sel;

  // Translate a latched row and one-hot-low column into the keypad's key code.
  function automatic logic [3:0] f_key_map(input logic [1:0] row, input logic [3:0] col);
    logic [1:0] c;
    logic [3:0] code;
    case (col)
      4'b1110: c = 2'd0;
      4'b1101: c = 2'd1;
      4'b1011: c = 2'd2;
      4'b0111: c = 2'd3;
      default: c = 2'd0;
    endcase
    case ({row, c})
      4'h0: code = 4'h1;
      4'h1: code = 4'h2;
      4'h2: code = 4'h3;
      4'h3: code = 4'hA;
      4'h4: code = 4'h4;
      4'h5: code = 4'h5;
      4'h6: code = 4'h6;
      4'h7: code = 4'hB;
      4'h8: code = 4'h7;
      4'h9: code = 4'h8;
      4'hA: code = 4'h9;
      4'hB: code = 4'hC;
      4'hC: code = 4'hE;
      4'hD: code = 4'h0;
      4'hE: code = 4'hF;
      default: code = 4'hD;
    endcase
    return code;
  endfunction

  // Two-flop column synchroniser with a matching row-index delay so r_row_d2 names the row
  // that produced r_col_s2.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_col_s1 <= 4'hF;
      r_col_s2 <= 4'hF;
      r_row_d1 <= 2'd0;
      r_row_d2 <= 2'd0;
    end else begin
      r_col_s1 <= i_col_n;
      r_col_s2 <= r_col_s1;
      r_row_d1 <= i_cont_out;
      r_row_d2 <= r_row_d1;
    end
  end

  // Exactly one column low; multi-key presses are treated as no press.
  always_comb begin
    w_one_low = 1'b0;
    case (r_col_s2)
      4'b1110, 4'b1101, 4'b1011, 4'b0111: w_one_low = 1'b1;
      default:                            w_one_low = 1'b0;
    endcase
  end

  // FSM state, debounce counter and latched key position.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_state   <= StScan;
      r_cnt     <= '0;
      r_row_lat <= 2'd0;
      r_col_lat <= 4'hF;
    end else begin
      r_state   <= w_state_next;
      r_cnt     <= w_cnt_next;
      r_row_lat <= w_row_lat_next;
      r_col_lat <= w_col_lat_next;
    end
  end

  // Next-state logic and the stop request.
  always_comb begin
    w_state_next   = r_state;
    w_cnt_next     = r_cnt;
    w_row_lat_next = r_row_lat;
    w_col_lat_next = r_col_lat;
    w_stop         = 1'b1;
    unique case (r_state)
      StScan: begin
        w_stop = 1'b0;
        if (w_one_low) begin
          w_row_lat_next = r_row_d2;
          w_col_lat_next = r_col_s2;
          w_cnt_next     = '0;
          w_state_next   = StDebPress;
        end
      end
      StDebPress: begin
        // The first two samples still come from the scanning rows, so they are ignored.
        if ((r_cnt < Settle) || (r_col_s2 == r_col_lat)) begin
          w_cnt_next = r_cnt + 1'b1;
          if (r_cnt == PressLast) begin
            w_state_next = StEmit;
          end
        end else begin
          w_state_next = StScan;
        end
      end
      StEmit: begin
        w_state_next = StHold;
      end
      StHold: begin
        if (r_col_s2 == 4'hF) begin
          w_cnt_next   = '0;
          w_state_next = StDebRel;
        end
      end
      StDebRel: begin
        if (r_col_s2 == 4'hF) begin
          w_cnt_next = r_cnt + 1'b1;
          if (r_cnt == RelLast) begin
            w_state_next = StScan;
          end
        end else begin
          w_cnt_next   = '0;
          w_state_next = StHold;
        end
      end
      default: begin
        w_state_next = StScan;
      end
    endcase
  end

  // Key code register and one-cycle valid strobe, loaded from the EMIT state.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_key_code  <= 4'h0;
      r_key_valid <= 1'b0;
    end else begin
      r_key_valid <= (r_state == StEmit);
      if (r_state == StEmit) begin
        r_key_code <= f_key_map(r_row_lat, r_col_lat);
      end
    end
  end

  // Row drive follows the scan counter only while scanning; otherwise it parks on the
  // latched row so scanner overrun after a freeze request is harmless.
  always_comb begin
    w_row_sel = (r_state == StScan) ? i_cont_out : r_row_lat;
    o_row_n   = ~(4'b0001 << w_row_sel);
  end

  assign o_stop      = w_stop;
  assign o_key_code  = r_key_code;
  assign o_key_valid = r_key_valid;

endmodule

// File: tb/tb_module_keypad_decoder.sv
// Self-checking bench for module_keypad_decoder: a row counter that freezes on stop, a
// physical keypad model resolving columns from the driven rows, and scenario tasks.
module tb_module_keypad_decoder;

  localparam int Deb = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [1:0] cont_out;
  logic [3:0] col_n;
  logic [3:0] row_n;
  logic       stop;
  logic [3:0] key_code;
  logic       key_valid;

  int n_checks = 0;
  int n_fail   = 0;

  // Scanner model: advances one row per cycle unless frozen.
  logic [1:0] cont_model;
  logic [1:0] cont_force = 2'd2;
  logic       cont_run   = 1'b0;

  // Keypad model: bit r*4+c set means key (row r, col c) is held down.
  logic [15:0] pressed  = '0;
  logic        use_rand = 1'b0;
  logic [3:0]  rand_col = 4'hF;
  logic [3:0]  col_model;

  logic [3:0] key_tab [16];

  int   pulses  = 0;
  int   doubles = 0;
  logic prev_v  = 1'b0;

  module_keypad_decoder #(.DEBOUNCE_CYCLES(Deb)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_cont_out  (cont_out),
    .i_col_n     (col_n),
    .o_row_n     (row_n),
    .o_stop      (stop),
    .o_key_code  (key_code),
    .o_key_valid (key_valid)
  );

  always #5 clk = ~clk;

  always @(posedge clk or negedge rst) begin
    if (!rst) cont_model <= 2'd0;
    else if (!stop) cont_model <= cont_model + 2'd1;
  end

  assign cont_out = cont_run ? cont_model : cont_force;

  always_comb begin
    col_model = 4'hF;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (!row_n[r] && pressed[r*4+c]) col_model[c] = 1'b0;
      end
    end
  end

  assign col_n = use_rand ? rand_col : col_model;

  always @(negedge clk) begin
    if (key_valid) pulses <= pulses + 1;
    if (key_valid && prev_v) doubles <= doubles + 1;
    prev_v <= key_valid;
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Counts negedges until stop equals lvl; -1 when the bound expires.
  task automatic wait_stop(input logic lvl, input int limit, output int cyc);
    cyc = 0;
    @(negedge clk);
    while (stop !== lvl && cyc < limit) begin
      @(negedge clk);
      cyc++;
    end
    if (stop !== lvl) cyc = -1;
  endtask

  // Counts negedges until key_valid is seen; -1 when the bound expires.
  task automatic wait_valid(input int limit, output int cyc);
    cyc = 0;
    while (key_valid !== 1'b1 && cyc < limit) begin
      @(negedge clk);
      cyc++;
    end
    if (key_valid !== 1'b1) cyc = -1;
  endtask

  task automatic test_reset();
    logic [3:0] exp_row [4];
    exp_row = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    rst = 1'b0;
    use_rand = 1'b1;
    for (int i = 0; i < 5; i++) begin
      rand_col = 4'($urandom);
      step(1);
    end
    n_checks++;
    if (stop !== 1'b0) begin n_fail++; $display("FAIL reset_stop: got %b want 0", stop); end
    n_checks++;
    if (key_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_valid: got %b want 0", key_valid);
    end
    n_checks++;
    if (key_code !== 4'h0) begin
      n_fail++; $display("FAIL reset_code: got %h want 0", key_code);
    end
    n_checks++;
    if (row_n !== 4'b1011) begin
      n_fail++; $display("FAIL reset_row_n: got %b want 1011", row_n);
    end
    use_rand = 1'b0;
    pressed  = '0;
    @(negedge clk);
    rst = 1'b1;
    step(3);
    for (int v = 0; v < 4; v++) begin
      cont_force = 2'(v);
      #1;
      n_checks++;
      if (row_n !== exp_row[v]) begin
        n_fail++; $display("FAIL row_track_%0d: got %b want %b", v, row_n, exp_row[v]);
      end
    end
    cont_run = 1'b1;
    step(4);
  endtask

  // Clean press of (r,c) held for extra cycles after the pulse, then released.
  task automatic do_press(input string nm, input int r, input int c, input int hold);
    int cyc;
    int lat;
    int p0;
    logic [3:0] exp_code;
    exp_code = key_tab[r*4+c];
    p0 = pulses;
    pressed[r*4+c] = 1'b1;
    wait_stop(1'b1, 40, cyc);
    n_checks++;
    if (cyc < 0) begin n_fail++; $display("FAIL %s_detect: got timeout want stop=1", nm); end
    wait_valid(80, lat);
    n_checks++;
    if (lat != Deb + 3) begin
      n_fail++; $display("FAIL %s_latency: got %0d want %0d", nm, lat, Deb + 3);
    end
    n_checks++;
    if (key_code !== exp_code) begin
      n_fail++; $display("FAIL %s_code: got %h want %h", nm, key_code, exp_code);
    end
    @(negedge clk);
    n_checks++;
    if (key_valid !== 1'b0) begin
      n_fail++; $display("FAIL %s_strobe_width: got %b want 0", nm, key_valid);
    end
    step(hold + 1);
    n_checks++;
    if (stop !== 1'b1) begin n_fail++; $display("FAIL %s_held_stop: got %b want 1", nm, stop); end
    pressed[r*4+c] = 1'b0;
    wait_stop(1'b0, 80, cyc);
    n_checks++;
    if (cyc != Deb + 3) begin
      n_fail++; $display("FAIL %s_release: got %0d want %0d", nm, cyc, Deb + 3);
    end
    #1;
    n_checks++;
    if (pulses - p0 != 1) begin
      n_fail++; $display("FAIL %s_pulses: got %0d want 1", nm, pulses - p0);
    end
    n_checks++;
    if (key_code !== exp_code) begin
      n_fail++; $display("FAIL %s_code_hold: got %h want %h", nm, key_code, exp_code);
    end
    step(3);
  endtask

  task automatic test_clean_press();
    do_press("key5", 1, 1, 10);
  endtask

  task automatic test_random_keys();
    int r;
    int c;
    for (int i = 0; i < 8; i++) begin
      r = int'($urandom_range(0, 3));
      c = int'($urandom_range(0, 3));
      do_press($sformatf("rand%0d", i), r, c, int'($urandom_range(0, 20)));
      step(int'($urandom_range(0, 7)));
    end
  endtask

  task automatic test_two_keys();
    int p0;
    int stop_hi;
    p0 = pulses;
    stop_hi = 0;
    pressed[0] = 1'b1;
    pressed[3] = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (stop) stop_hi++;
    end
    n_checks++;
    if (stop_hi != 0) begin n_fail++; $display("FAIL two_keys_stop: got %0d want 0", stop_hi); end
    #1;
    n_checks++;
    if (pulses != p0) begin
      n_fail++; $display("FAIL two_keys_pulses: got %0d want 0", pulses - p0);
    end
    pressed = '0;
    step(4);
  endtask

  task automatic test_bouncy();
    int p0;
    int cyc;
    p0 = pulses;
    for (int i = 0; i < 5; i++) begin
      pressed[14] = (i % 2 == 0);
      step(1);
    end
    wait_valid(120, cyc);
    n_checks++;
    if (cyc < 0) begin n_fail++; $display("FAIL bouncy_valid: got timeout want pulse"); end
    n_checks++;
    if (key_code !== 4'hF) begin n_fail++; $display("FAIL bouncy_code: got %h want f", key_code); end
    step(10);
    pressed[14] = 1'b0;
    wait_stop(1'b0, 80, cyc);
    #1;
    n_checks++;
    if (pulses - p0 != 1) begin
      n_fail++; $display("FAIL bouncy_pulses: got %0d want 1", pulses - p0);
    end
    step(3);
  endtask

  task automatic test_release_bounce();
    int p0;
    int cyc;
    p0 = pulses;
    pressed[15] = 1'b1;
    wait_valid(120, cyc);
    n_checks++;
    if (key_code !== 4'hD) begin n_fail++; $display("FAIL relb_code: got %h want d", key_code); end
    step(4);
    pressed[15] = 1'b0;
    step(8);
    pressed[15] = 1'b1;
    step(1);
    pressed[15] = 1'b0;
    wait_stop(1'b0, 80, cyc);
    n_checks++;
    if (cyc != Deb + 3) begin
      n_fail++; $display("FAIL relb_release: got %0d want %0d", cyc, Deb + 3);
    end
    #1;
    n_checks++;
    if (pulses - p0 != 1) begin
      n_fail++; $display("FAIL relb_pulses: got %0d want 1", pulses - p0);
    end
    step(3);
  endtask

  task automatic test_hold_other_key();
    int p0;
    int cyc;
    p0 = pulses;
    pressed[5] = 1'b1;
    wait_valid(120, cyc);
    n_checks++;
    if (key_code !== 4'h5) begin n_fail++; $display("FAIL other_code: got %h want 5", key_code); end
    step(3);
    pressed[6] = 1'b1;
    step(3);
    pressed[5] = 1'b0;
    step(Deb + 10);
    n_checks++;
    if (stop !== 1'b1) begin n_fail++; $display("FAIL other_stop: got %b want 1", stop); end
    pressed[6] = 1'b0;
    wait_stop(1'b0, 80, cyc);
    n_checks++;
    if (cyc != Deb + 3) begin
      n_fail++; $display("FAIL other_release: got %0d want %0d", cyc, Deb + 3);
    end
    #1;
    n_checks++;
    if (pulses - p0 != 1) begin
      n_fail++; $display("FAIL other_pulses: got %0d want 1", pulses - p0);
    end
    n_checks++;
    if (key_code !== 4'h5) begin
      n_fail++; $display("FAIL other_code_hold: got %h want 5", key_code);
    end
    step(3);
  endtask

  task automatic test_reset_mid();
    int p0;
    int cyc;
    int lat;
    p0 = pulses;
    pressed[0] = 1'b1;
    wait_stop(1'b1, 40, cyc);
    step(5);
    #2;
    rst = 1'b0;
    #1;
    n_checks++;
    if (stop !== 1'b0) begin n_fail++; $display("FAIL rstmid_stop: got %b want 0", stop); end
    step(3);
    n_checks++;
    if (key_valid !== 1'b0) begin
      n_fail++; $display("FAIL rstmid_valid: got %b want 0", key_valid);
    end
    @(negedge clk);
    rst = 1'b1;
    wait_stop(1'b1, 40, cyc);
    n_checks++;
    if (cyc < 0) begin n_fail++; $display("FAIL rstmid_redetect: got timeout want stop=1"); end
    wait_valid(80, lat);
    n_checks++;
    if (lat != Deb + 3) begin
      n_fail++; $display("FAIL rstmid_latency: got %0d want %0d", lat, Deb + 3);
    end
    n_checks++;
    if (key_code !== 4'h1) begin n_fail++; $display("FAIL rstmid_code: got %h want 1", key_code); end
    step(2);
    pressed[0] = 1'b0;
    wait_stop(1'b0, 80, cyc);
    #1;
    n_checks++;
    if (pulses - p0 != 1) begin
      n_fail++; $display("FAIL rstmid_pulses: got %0d want 1", pulses - p0);
    end
    step(3);
  endtask

  task automatic test_no_double();
    n_checks++;
    if (doubles != 0) begin
      n_fail++; $display("FAIL valid_back_to_back: got %0d want 0", doubles);
    end
  endtask

  initial begin
    key_tab = '{4'h1, 4'h2, 4'h3, 4'hA, 4'h4, 4'h5, 4'h6, 4'hB,
                4'h7, 4'h8, 4'h9, 4'hC, 4'hE, 4'h0, 4'hF, 4'hD};
    test_reset();
    test_clean_press();
    test_random_keys();
    test_two_keys();
    test_bouncy();
    test_release_bounce();
    test_hold_other_key();
    test_reset_mid();
    test_no_double();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/module_keypad_decoder.md
# module_keypad_decoder

Consumes the 2-bit row index from `module_cont_2b` and scans a 4x4 matrix keypad. It drives the active-low row lines and synchronises the active-low column lines. It debounces a single key press and emits a 4-bit key code with a one-cycle valid pulse to the operand-entry logic of the multiplier. While a key is being qualified or held, it asserts `stop` back to `module_cont_2b` to freeze scanning.

## Interface
- `DEBOUNCE_CYCLES`, default 16: number of consecutive stable synchronised samples required to accept a press or a release.
- `clk`  input  1  system clock; all state changes on the rising edge.
- `rst`  input  1  asynchronous, active-low reset.
- `cont_out`  input  2  row index from `module_cont_2b`.
- `col_n`  input  4  raw keypad columns, active-low, asynchronous to `clk`.
- `row_n`  output  4  keypad row drive, active-low, one-hot-low.
- `stop`  output  1  freeze request to `module_cont_2b`.
- `key_code`  output  4  code of the last accepted key.
- `key_valid`  output  1  single-cycle strobe when `key_code` updates.

## Operation
- **Column synchroniser**
  - `col_n` passes through a 2-flop synchroniser, giving `col_s`.
  - `cont_out` passes through a matching 2-stage delay, giving `row_d2`, so `row_d2` names the row that produced `col_s`.
- **Row drive**
  - Combinational.
  - In SCAN: `row_n = ~(4'b0001 << cont_out)`.
  - In every other state: `row_n = ~(4'b0001 << row_lat)`.
- **Key map**
  - Row r, column c; column 0 = bit 0.
  - Row 0: 1, 2, 3, A → 0x1, 0x2, 0x3, 0xA.
  - Row 1: 4, 5, 6, B → 0x4, 0x5, 0x6, 0xB.
  - Row 2: 7, 8, 9, C → 0x7, 0x8, 0x9, 0xC.
  - Row 3: *, 0, #, D → 0xE, 0x0, 0xF, 0xD.
- **FSM states:** SCAN, DEB_PRESS, EMIT, HOLD, DEB_REL.
  - **SCAN**
    - `stop=0`.
    - If `col_s` has exactly one bit low: latch `row_lat=row_d2` and `col_lat=col_s`, clear `cnt`, go to DEB_PRESS.
    - Zero or more than one low bit: stay in SCAN (multi-key presses are ignored).
  - **DEB_PRESS**
    - `stop=1`.
    - For the first 2 cycles (`cnt` 0..1), `col_s` is ignored while the synchroniser settles to the latched row.
    - From `cnt=2` onward: if `col_s==col_lat`, increment `cnt`; otherwise go to SCAN.
    - When `cnt` reaches `DEBOUNCE_CYCLES+2`, go to EMIT.
  - **EMIT**
    - `stop=1`.
    - `key_code` ← map(`row_lat`, `col_lat`), and `key_valid=1` for exactly this cycle.
    - Then go to HOLD.
  - **HOLD**
    - `stop=1`.
    - When `col_s==4'b1111`, clear `cnt` and go to DEB_REL.
  - **DEB_REL**
    - `stop=1`.
    - If `col_s==4'b1111`, increment `cnt`; any low bit clears `cnt` and returns to HOLD.
    - When `cnt` reaches `DEBOUNCE_CYCLES`, go to SCAN. No second `key_valid` is produced.
- `cnt` is wide enough to hold `DEBOUNCE_CYCLES+2` without wrap: `$clog2(DEBOUNCE_CYCLES+3)` bits.

## Timing
- **Reset values** (`rst=0`, asynchronous): state SCAN, `stop=0`, `key_valid=0`, `key_code=4'h0`, `cnt=0`, `row_lat=0`, `col_lat=4'hF`, synchroniser flops all 1, `row_d2` stages 0. `row_n` follows `cont_out` immediately.
- **Reset mid-operation** (any state): the FSM returns to SCAN, `stop` drops in the same cycle, and no `key_valid` is issued.
- **Press latency**
  - First low `col_n` edge to detection in SCAN: 2 cycles.
  - Detection to `key_valid`: `DEBOUNCE_CYCLES+3` cycles (settle + debounce + EMIT).
- **`stop` timing:** asserts the cycle after detection. `module_cont_2b` may advance up to 3 positions before freezing; this is harmless because `row_n` is driven from `row_lat`.
- **`key_code` hold:** `key_code` holds its value until the next EMIT. `key_valid` is never high for 2 consecutive cycles.
- **Bounce during DEB_PRESS:** a single mismatching `col_s` sample after settle aborts to SCAN with no output.
- **Bounce during DEB_REL:** a low sample restarts the release qualification via HOLD.
- **Simultaneous events:** a different key pressed while in HOLD is ignored until full release, i.e. all columns high for `DEBOUNCE_CYCLES` cycles.

## Test plan
- Reset: hold `rst=0` with `col_n` random → `stop=0`, `key_valid=0`, `key_code=0`. Release: `row_n` tracks `cont_out`, e.g. `cont_out=2` → `row_n=4'b1011`.
- Clean press of key "5" (row 1, col 1 pulled low while row 1 is driven) → exactly one `key_valid` pulse with `key_code=4'h5`, `DEBOUNCE_CYCLES+3` cycles after detection. `stop` stays 1 until release plus 16 stable high cycles.
- Bouncy press of "#" (col 2 toggling 3 times within 5 cycles, then stable on row 3) → no output from the bounces, then a single pulse with `key_code=4'hF`. `stop` returns to 0 in between aborted attempts.
- Two keys on the same row (col 0 and col 3 low together) → stays in SCAN, `stop=0`, no `key_valid`.
- Release bounce on "D": after the pulse (`key_code=4'hD`), columns glitch low once during DEB_REL → no second pulse, and SCAN is reached only after 16 clean high cycles.
- `rst` pulsed low during DEB_PRESS of key "1" → `stop` falls asynchronously, no `key_valid`. A press held after reset is re-detected and produces `key_code=4'h1`.
